// File: rtl/dtc_pkg.sv
// Shared types and helpers for the programmable decision-tree engine.
// Node words are decoded into a max-width struct so one type serves every parameter set.
package dtc_pkg;

    localparam int unsigned MAX_FW     = 8;
    localparam int unsigned MAX_AW     = 16;
    localparam int unsigned MAX_CLS_W  = 8;
    localparam int unsigned MAX_NODE_W = 1 + MAX_FW + 2 * MAX_AW + MAX_CLS_W;

    typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

    typedef struct packed {
        logic                 leaf;
        logic [MAX_FW-1:0]    feat;
        logic [MAX_AW-1:0]    hi;
        logic [MAX_AW-1:0]    lo;
        logic [MAX_CLS_W-1:0] cls;
    } node_t;

    function automatic int unsigned clog2s(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned node_width(input int unsigned fw, input int unsigned aw,
                                               input int unsigned cw);
        return 1 + fw + 2 * aw + cw;
    endfunction

    function automatic logic [MAX_NODE_W-1:0] low_mask(input int unsigned k);
        return (MAX_NODE_W'(1) << k) - MAX_NODE_W'(1);
    endfunction

    // Word layout, MSB first: {leaf, feat, hi, lo, cls}.
    function automatic node_t node_unpack(input logic [MAX_NODE_W-1:0] w, input int unsigned fw,
                                          input int unsigned aw, input int unsigned cw);
        node_t                 n;
        logic [MAX_NODE_W-1:0] s;
        n = '0;
        s = w;
        for (int unsigned i = 0; i < MAX_CLS_W; i++) if (i < cw) n.cls[i] = s[i];
        s = s >> cw;
        for (int unsigned i = 0; i < MAX_AW; i++) if (i < aw) n.lo[i] = s[i];
        s = s >> aw;
        for (int unsigned i = 0; i < MAX_AW; i++) if (i < aw) n.hi[i] = s[i];
        s = s >> aw;
        for (int unsigned i = 0; i < MAX_FW; i++) if (i < fw) n.feat[i] = s[i];
        s = s >> fw;
        n.leaf = s[0];
        return n;
    endfunction

    function automatic logic [MAX_NODE_W-1:0] node_pack(input node_t n, input int unsigned fw,
                                                        input int unsigned aw,
                                                        input int unsigned cw);
        logic [MAX_NODE_W-1:0] w;
        w = MAX_NODE_W'(n.leaf);
        w = (w << fw) | (MAX_NODE_W'(n.feat) & low_mask(fw));
        w = (w << aw) | (MAX_NODE_W'(n.hi) & low_mask(aw));
        w = (w << aw) | (MAX_NODE_W'(n.lo) & low_mask(aw));
        w = (w << cw) | (MAX_NODE_W'(n.cls) & low_mask(cw));
        return w;
    endfunction

    // True when no field carries bits beyond its configured width.
    function automatic logic node_fits(input node_t n, input int unsigned fw,
                                       input int unsigned aw, input int unsigned cw);
        return ((MAX_NODE_W'(n.feat) & ~low_mask(fw)) == '0) &&
               ((MAX_NODE_W'(n.hi) & ~low_mask(aw)) == '0) &&
               ((MAX_NODE_W'(n.lo) & ~low_mask(aw)) == '0) &&
               ((MAX_NODE_W'(n.cls) & ~low_mask(cw)) == '0);
    endfunction

endpackage

// File: rtl/dtc_node_table.sv
// Writable node table: one synchronous write port, one combinational read port.
// Reset turns every entry into a class-0 leaf.
module dtc_node_table #(
    parameter int unsigned N_NODES = 64,
    parameter int unsigned AW      = 6,
    parameter int unsigned NODE_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [NODE_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [NODE_W-1:0] rdata
);

    localparam logic [NODE_W-1:0] LEAF0 = {1'b1, {(NODE_W - 1){1'b0}}};

    logic [NODE_W-1:0] mem [N_NODES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_NODES); i++) mem[i] <= LEAF0;
        end else if (we && (32'(waddr) < N_NODES)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = (32'(raddr) < N_NODES) ? mem[raddr] : LEAF0;

endmodule

// File: rtl/dtc_prog_engine.sv
// Sequential decision-tree classifier: walks a programmable node table one node per clock,
// with valid/ready handshakes on input and output and a config port for loading trees.
module dtc_prog_engine
    import dtc_pkg::*;
#(
    parameter  int unsigned N_FEAT    = 12,
    parameter  int unsigned CLS_W     = 3,
    parameter  int unsigned N_NODES   = 64,
    parameter  int unsigned MAX_DEPTH = 16,
    localparam int unsigned AW        = clog2s(N_NODES),
    localparam int unsigned FW        = clog2s(N_FEAT),
    localparam int unsigned NODE_W    = node_width(FW, AW, CLS_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_FEAT-1:0] inp,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CLS_W-1:0]  outp,
    output logic              out_err,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              cfg_we,
    input  logic [AW-1:0]     cfg_addr,
    input  logic [NODE_W-1:0] cfg_wdata,
    output logic              cfg_ready
);

    localparam int unsigned DW = clog2s(MAX_DEPTH);

    state_e              state_q, state_d;
    logic [N_FEAT-1:0]   inp_q, inp_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic [CLS_W-1:0]    outp_q, outp_d;
    logic                err_q, err_d;
    logic [NODE_W-1:0]   rdata;
    node_t               node;
    logic                sel_bit;
    logic [MAX_AW-1:0]   child;

    dtc_node_table #(
        .N_NODES (N_NODES),
        .AW      (AW),
        .NODE_W  (NODE_W)
    ) u_table (
        .clk   (clk),
        .rst   (rst),
        .we    (cfg_we && (state_q == StIdle)),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (ptr_q),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            inp_q   <= '0;
            ptr_q   <= '0;
            depth_q <= '0;
            outp_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inp_q   <= inp_d;
            ptr_q   <= ptr_d;
            depth_q <= depth_d;
            outp_q  <= outp_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        inp_d   = inp_q;
        ptr_d   = ptr_q;
        depth_d = depth_q;
        outp_d  = outp_q;
        err_d   = err_q;
        node    = node_unpack(MAX_NODE_W'(rdata), FW, AW, CLS_W);
        sel_bit = 1'b0;
        for (int unsigned i = 0; i < N_FEAT; i++) begin
            if (32'(node.feat) == i) sel_bit = inp_q[i];
        end
        child = sel_bit ? node.hi : node.lo;

        unique case (state_q)
            StIdle: begin
                if (in_valid && in_ready) begin
                    inp_d   = inp;
                    ptr_d   = '0;
                    depth_d = '0;
                    state_d = StWalk;
                end
            end
            StWalk: begin
                if (!node_fits(node, FW, AW, CLS_W)) begin
                    outp_d  = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (node.leaf) begin
                    outp_d  = node.cls[CLS_W-1:0];
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if ((32'(node.feat) >= N_FEAT) || (32'(child) >= N_NODES) ||
                             (32'(depth_q) == MAX_DEPTH - 1)) begin
                    // Bad pointer or depth overrun; the depth cap also stops cyclic trees.
                    outp_d  = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    ptr_d   = child[AW-1:0];
                    depth_d = depth_q + DW'(1);
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_ready  = (state_q == StIdle) && !cfg_we;
    assign cfg_ready = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign outp      = outp_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_dtc_prog_engine.sv
// Scoreboard bench for dtc_prog_engine: the driver queues expected results at acceptance,
// an independent monitor checks class, error flag, latency and DONE-state stability.
module tb_dtc_prog_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] inp;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  outp;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [19:0] cfg_wdata;
    logic        cfg_ready;

    dtc_prog_engine dut (
        .clk       (clk),
        .rst       (rst),
        .inp       (inp),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .outp      (outp),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ready (cfg_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] cls;
        logic       err;
        int         d;
        longint     t_acc;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [19:0] node(input logic leaf, input logic [3:0] feat,
                                         input logic [5:0] hi, input logic [5:0] lo,
                                         input logic [2:0] cls);
        return {leaf, feat, hi, lo, cls};
    endfunction

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    logic       in_done = 1'b0;
    logic       unstable;
    logic [2:0] cap_cls;
    logic       cap_err;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (!in_done) begin
                in_done  = 1'b1;
                unstable = 1'b0;
                cap_cls  = outp;
                cap_err  = out_err;
                if (q.size() == 0) chk("unexpected_out", 1, 0);
                else chk("latency", int'(($time - q[0].t_acc - 5) / 10), q[0].d + 1);
            end else if (outp !== cap_cls || out_err !== cap_err || in_ready || cfg_ready) begin
                unstable = 1'b1;
            end
            if (out_ready) begin
                if (q.size() != 0) begin
                    chk("class", int'(outp), int'(q[0].cls));
                    chk("err", int'(out_err), int'(q[0].err));
                    chk("done_hold", int'(unstable), 0);
                    void'(q.pop_front());
                end
                in_done = 1'b0;
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [11:0] v, input logic [2:0] cls, input logic err,
                        input int d, input bit track);
        exp_t e;
        bit   ok = 1'b0;
        inp      = v;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
        end else if (track) begin
            e.cls   = cls;
            e.err   = err;
            e.d     = d;
            e.t_acc = longint'($time);
            q.push_back(e);
        end
        #1;
        in_valid = 1'b0;
        inp      = ~v;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 200 && q.size() != 0; n++) @(posedge clk);
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [19:0] w);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = w;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        inp       = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_outp", int'(outp), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        @(posedge clk);
        #1;

        // Fresh tree: root is a class-0 leaf.
        send(12'hFFF, 3'd0, 1'b0, 0, 1'b1);
        wait_drain();

        // One split on feature 9.
        cfg_write(6'd0, node(1'b0, 4'd9, 6'd1, 6'd2, 3'd0));
        cfg_write(6'd1, node(1'b1, 4'd0, 6'd0, 6'd0, 3'd0));
        cfg_write(6'd2, node(1'b1, 4'd0, 6'd0, 6'd0, 3'd7));
        send(12'h200, 3'd0, 1'b0, 1, 1'b1);
        send(12'h000, 3'd7, 1'b0, 1, 1'b1);
        wait_drain();

        // Two levels: node2 splits on feature 11.
        cfg_write(6'd2, node(1'b0, 4'd11, 6'd3, 6'd4, 3'd0));
        cfg_write(6'd3, node(1'b1, 4'd0, 6'd0, 6'd0, 3'd5));
        cfg_write(6'd4, node(1'b1, 4'd0, 6'd0, 6'd0, 3'd2));
        send(12'h800, 3'd5, 1'b0, 2, 1'b1);
        send(12'h000, 3'd2, 1'b0, 2, 1'b1);
        send(12'hA00, 3'd0, 1'b0, 1, 1'b1);
        wait_drain();

        // Stall in DONE; a config write there must be dropped.
        cfg_write(6'd2, node(1'b1, 4'd0, 6'd0, 6'd0, 3'd7));
        out_ready = 1'b0;
        send(12'h000, 3'd7, 1'b0, 1, 1'b1);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        @(posedge clk);
        #1;
        cfg_write(6'd0, node(1'b1, 4'd0, 6'd0, 6'd0, 3'd5));
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain();
        send(12'h000, 3'd7, 1'b0, 1, 1'b1);
        wait_drain();

        // Feature index beyond N_FEAT.
        cfg_write(6'd0, node(1'b0, 4'd13, 6'd1, 6'd2, 3'd0));
        send(12'hFFF, 3'd0, 1'b1, 0, 1'b1);
        wait_drain();

        // Config write and input together: write wins, vector follows on the new root.
        cfg_we    = 1'b1;
        cfg_addr  = 6'd0;
        cfg_wdata = node(1'b1, 4'd0, 6'd0, 6'd0, 3'd6);
        in_valid  = 1'b1;
        inp       = 12'h123;
        @(negedge clk);
        chk("cfg_prio_in_ready", int'(in_ready), 0);
        @(posedge clk);
        #1 cfg_we = 1'b0;
        send(12'h123, 3'd6, 1'b0, 0, 1'b1);
        wait_drain();

        // Self-loop trips the depth limit.
        cfg_write(6'd0, node(1'b0, 4'd0, 6'd0, 6'd0, 3'd3));
        send(12'hFFF, 3'd0, 1'b1, 15, 1'b1);
        wait_drain();

        // Reset in the middle of a walk (depth 3).
        send(12'h000, 3'd0, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        send(12'h000, 3'd0, 1'b0, 0, 1'b1);
        send(12'hFFF, 3'd0, 1'b0, 0, 1'b1);
        send(12'h5A5, 3'd0, 1'b0, 0, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
